// File: rtl/vcc_pok_rst_seq.sv
// vcc_pok_rst_seq: consumer end of the VCC power-good interface.
// Synchronizes and debounces the asynchronous power-ok level, filters
// short drop-outs, sequences power-on-reset release to the reset manager
// through a req/ack handshake and counts power-loss events from ACTIVE.
//
// Ports:
//   clk_i        always-on clock
//   rst_i        asynchronous, active-high reset
//   vcc_pok_i    asynchronous power-ok level from the power-good detector
//   pok_o        filtered, synchronous power-ok
//   por_rst_o    active-high power-on reset to downstream logic
//   rel_req_o    reset-release request to the reset manager
//   rel_ack_i    reset-release acknowledge, synchronous to clk_i
//   glitch_cnt_o saturating count of power-loss events from ACTIVE
`timescale 1ns/1ps

module vcc_pok_rst_seq #(
    parameter int SyncStages     = 2,
    parameter int AssertCycles   = 16,
    parameter int DeassertCycles = 2,
    parameter int RelDelay       = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       vcc_pok_i,
    output logic       pok_o,
    output logic       por_rst_o,
    output logic       rel_req_o,
    input  logic       rel_ack_i,
    output logic [7:0] glitch_cnt_o
);

    localparam int MaxAR  = (AssertCycles > RelDelay) ? AssertCycles : RelDelay;
    localparam int MaxCnt = (MaxAR > DeassertCycles) ? MaxAR : DeassertCycles;
    localparam int CW     = $clog2(MaxCnt + 1);

    localparam logic [CW-1:0] AssertLast   = CW'(AssertCycles - 1);
    localparam logic [CW-1:0] RelLast      = CW'(RelDelay - 1);
    localparam logic [CW-1:0] DeassertLast = CW'(DeassertCycles - 1);
    localparam logic [CW-1:0] CntOne       = CW'(1);

    localparam logic [2:0] ST_OFF      = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_DELAY    = 3'd2;
    localparam logic [2:0] ST_REQ      = 3'd3;
    localparam logic [2:0] ST_ACTIVE   = 3'd4;

    // Synchronizer
    logic [SyncStages-1:0] sync_q;
    logic                  pok_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], vcc_pok_i};
        end
    end

    assign pok_s = sync_q[SyncStages-1];

    // FSM state and registered outputs
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] lowcnt_q, lowcnt_d;
    logic          pok_q, pok_d;
    logic          por_q, por_d;
    logic          req_q, req_d;
    logic [7:0]    glitch_q, glitch_d;

    logic in_filter;
    logic loss;

    // Drop-out filter only applies once power has been declared good.
    assign in_filter = (state_q == ST_DELAY) ||
                       (state_q == ST_REQ)   ||
                       (state_q == ST_ACTIVE);

    // The edge on which the low run reaches DeassertCycles.
    assign loss = in_filter && !pok_s && (lowcnt_q == DeassertLast);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lowcnt_d = lowcnt_q;
        pok_d    = pok_q;
        por_d    = por_q;
        req_d    = req_q;
        glitch_d = glitch_q;

        unique case (state_q)
            ST_OFF: begin
                pok_d    = 1'b0;
                por_d    = 1'b1;
                req_d    = 1'b0;
                cnt_d    = '0;
                lowcnt_d = '0;
                if (pok_s) begin
                    state_d = ST_DEBOUNCE;
                end
            end

            ST_DEBOUNCE: begin
                lowcnt_d = '0;
                if (!pok_s) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == AssertLast) begin
                    state_d = ST_DELAY;
                    pok_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            ST_DELAY: begin
                if (cnt_q == RelLast) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            ST_REQ: begin
                if (rel_ack_i) begin
                    state_d = ST_ACTIVE;
                    req_d   = 1'b0;
                    por_d   = 1'b0;
                end
            end

            ST_ACTIVE: begin
                pok_d = 1'b1;
                por_d = 1'b0;
                req_d = 1'b0;
            end

            default: begin
                state_d  = ST_OFF;
                pok_d    = 1'b0;
                por_d    = 1'b1;
                req_d    = 1'b0;
                cnt_d    = '0;
                lowcnt_d = '0;
            end
        endcase

        if (in_filter) begin
            lowcnt_d = pok_s ? '0 : (lowcnt_q + CntOne);
        end

        // Loss overrides every transition above, including an ack in REQ.
        if (loss) begin
            state_d  = ST_OFF;
            pok_d    = 1'b0;
            por_d    = 1'b1;
            req_d    = 1'b0;
            cnt_d    = '0;
            lowcnt_d = '0;
            if (state_q == ST_ACTIVE && glitch_q != 8'hFF) begin
                glitch_d = glitch_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            lowcnt_q <= '0;
            pok_q    <= 1'b0;
            por_q    <= 1'b1;
            req_q    <= 1'b0;
            glitch_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lowcnt_q <= lowcnt_d;
            pok_q    <= pok_d;
            por_q    <= por_d;
            req_q    <= req_d;
            glitch_q <= glitch_d;
        end
    end

    assign pok_o        = pok_q;
    assign por_rst_o    = por_q;
    assign rel_req_o    = req_q;
    assign glitch_cnt_o = glitch_q;

endmodule

// File: tb/tb_vcc_pok_rst_seq.sv
// tb_vcc_pok_rst_seq: directed self-checking bench for vcc_pok_rst_seq.
// Default parameters; one task per scenario, expected values hand-derived.
`timescale 1ns/1ps

module tb_vcc_pok_rst_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       vcc_pok;
    logic       rel_ack;
    logic       pok;
    logic       por_rst;
    logic       rel_req;
    logic [7:0] glitch_cnt;

    int checks = 0;
    int fails  = 0;

    vcc_pok_rst_seq dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .vcc_pok_i    (vcc_pok),
        .pok_o        (pok),
        .por_rst_o    (por_rst),
        .rel_req_o    (rel_req),
        .rel_ack_i    (rel_ack),
        .glitch_cnt_o (glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        vcc_pok = 1'b0;
        rel_ack = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // From OFF with a cleared synchronizer: reaches ACTIVE after 28 edges.
    task automatic bring_up();
        vcc_pok = 1'b1;
        rel_ack = 1'b1;
        repeat (28) tick();
    endtask

    // Loss from ACTIVE at edge 4; the fourth low edge leaves the
    // synchronizer all-zero.
    task automatic drop_power();
        vcc_pok = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        vcc_pok = 1'b0;
        rel_ack = 1'b0;
        #1 rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({pok, por_rst, rel_req} !== 3'b010) begin
            fails++;
            $display("FAIL reset_outs pok/por/req=%b%b%b want 010",
                     pok, por_rst, rel_req);
        end
        checks++;
        if (glitch_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_glitch got %0d want 0", glitch_cnt);
        end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({pok, por_rst, rel_req} !== 3'b010) begin
            fails++;
            $display("FAIL reset_idle pok/por/req=%b%b%b want 010",
                     pok, por_rst, rel_req);
        end
    endtask

    task automatic test_clean_powerup();
        do_reset();
        vcc_pok = 1'b1;
        rel_ack = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            tick();
            checks++;
            if (pok !== (n >= 19)) begin
                fails++;
                $display("FAIL clean_pok edge %0d got %b want %b",
                         n, pok, (n >= 19));
            end
            checks++;
            if (rel_req !== (n == 27)) begin
                fails++;
                $display("FAIL clean_req edge %0d got %b want %b",
                         n, rel_req, (n == 27));
            end
            checks++;
            if (por_rst !== (n < 28)) begin
                fails++;
                $display("FAIL clean_por edge %0d got %b want %b",
                         n, por_rst, (n < 28));
            end
        end
        checks++;
        if (glitch_cnt !== 8'd0) begin
            fails++;
            $display("FAIL clean_glitch got %0d want 0", glitch_cnt);
        end
    endtask

    // Low at edge 11 only: OFF at edge 13, DEBOUNCE again at 14, pok at 30.
    task automatic test_debounce_glitch();
        do_reset();
        rel_ack = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            vcc_pok = (n != 11);
            tick();
            checks++;
            if (pok !== (n >= 30)) begin
                fails++;
                $display("FAIL deb_pok edge %0d got %b want %b",
                         n, pok, (n >= 30));
            end
            checks++;
            if (por_rst !== 1'b1) begin
                fails++;
                $display("FAIL deb_por edge %0d got %b want 1", n, por_rst);
            end
        end
    endtask

    task automatic test_short_drop();
        do_reset();
        bring_up();
        vcc_pok = 1'b0;
        tick();
        vcc_pok = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            checks++;
            if ({pok, por_rst, rel_req} !== 3'b100 || glitch_cnt !== 8'd0) begin
                fails++;
                $display("FAIL short1 cyc %0d pok/por/req=%b%b%b glitch=%0d want 100/0",
                         n, pok, por_rst, rel_req, glitch_cnt);
            end
        end
        // 3-cycle low: loss at edge 4, DEBOUNCE at 6, pok 22, req 30, ACTIVE 31.
        vcc_pok = 1'b0;
        for (int n = 1; n <= 31; n++) begin
            if (n == 4) vcc_pok = 1'b1;
            tick();
            if (n <= 3) begin
                checks++;
                if (pok !== 1'b1 || por_rst !== 1'b0) begin
                    fails++;
                    $display("FAIL short3_hold edge %0d pok=%b por=%b want 1/0",
                             n, pok, por_rst);
                end
            end else begin
                checks++;
                if (pok !== (n >= 22)) begin
                    fails++;
                    $display("FAIL short3_pok edge %0d got %b want %b",
                             n, pok, (n >= 22));
                end
                checks++;
                if (rel_req !== (n == 30) || por_rst !== (n < 31)) begin
                    fails++;
                    $display("FAIL short3_seq edge %0d req=%b por=%b want %b/%b",
                             n, rel_req, por_rst, (n == 30), (n < 31));
                end
                checks++;
                if (glitch_cnt !== 8'd1) begin
                    fails++;
                    $display("FAIL short3_glitch edge %0d got %0d want 1",
                             n, glitch_cnt);
                end
            end
        end
    endtask

    task automatic test_handshake_stall();
        do_reset();
        rel_ack = 1'b0;
        vcc_pok = 1'b1;
        repeat (27) tick();
        checks++;
        if ({pok, por_rst, rel_req} !== 3'b111) begin
            fails++;
            $display("FAIL stall_req pok/por/req=%b%b%b want 111",
                     pok, por_rst, rel_req);
        end
        for (int n = 1; n <= 50; n++) begin
            tick();
            checks++;
            if (rel_req !== 1'b1 || por_rst !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold cyc %0d req=%b por=%b want 1/1",
                         n, rel_req, por_rst);
            end
        end
        rel_ack = 1'b1;
        tick();
        checks++;
        if ({pok, por_rst, rel_req} !== 3'b100) begin
            fails++;
            $display("FAIL stall_ack pok/por/req=%b%b%b want 100",
                     pok, por_rst, rel_req);
        end
        rel_ack = 1'b0;
        drop_power();
        checks++;
        if (glitch_cnt !== 8'd1 || por_rst !== 1'b1) begin
            fails++;
            $display("FAIL stall_loss1 glitch=%0d por=%b want 1/1",
                     glitch_cnt, por_rst);
        end
        vcc_pok = 1'b1;
        repeat (27) tick();
        checks++;
        if (rel_req !== 1'b1) begin
            fails++;
            $display("FAIL stall_req2 got %b want 1", rel_req);
        end
        repeat (5) tick();
        vcc_pok = 1'b0;
        repeat (3) tick();
        checks++;
        if (rel_req !== 1'b1) begin
            fails++;
            $display("FAIL stall_lowhold got %b want 1", rel_req);
        end
        tick();
        checks++;
        if ({pok, por_rst, rel_req} !== 3'b010 || glitch_cnt !== 8'd1) begin
            fails++;
            $display("FAIL stall_loss pok/por/req=%b%b%b glitch=%0d want 010/1",
                     pok, por_rst, rel_req, glitch_cnt);
        end
    endtask

    // Continues from OFF with glitch count 1 and a cleared synchronizer.
    task automatic test_loss_ack_same_edge();
        rel_ack = 1'b0;
        vcc_pok = 1'b1;
        repeat (27) tick();
        checks++;
        if (rel_req !== 1'b1) begin
            fails++;
            $display("FAIL same_req got %b want 1", rel_req);
        end
        vcc_pok = 1'b0;
        repeat (3) tick();
        rel_ack = 1'b1;
        tick();
        checks++;
        if ({pok, por_rst, rel_req} !== 3'b010 || glitch_cnt !== 8'd1) begin
            fails++;
            $display("FAIL same_edge pok/por/req=%b%b%b glitch=%0d want 010/1",
                     pok, por_rst, rel_req, glitch_cnt);
        end
        repeat (3) tick();
        checks++;
        if (por_rst !== 1'b1 || rel_req !== 1'b0) begin
            fails++;
            $display("FAIL same_after por=%b req=%b want 1/0", por_rst, rel_req);
        end
        rel_ack = 1'b0;
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            bring_up();
            drop_power();
            checks++;
            if (glitch_cnt !== ((i + 1 > 255) ? 8'd255 : 8'(i + 1))) begin
                fails++;
                $display("FAIL sat_cnt event %0d got %0d want %0d", i + 1,
                         glitch_cnt, (i + 1 > 255) ? 255 : i + 1);
            end
        end
        rel_ack = 1'b0;
        vcc_pok = 1'b1;
        repeat (22) tick();
        checks++;
        if (pok !== 1'b1 || rel_req !== 1'b0) begin
            fails++;
            $display("FAIL delay_state pok=%b req=%b want 1/0", pok, rel_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pok, por_rst, rel_req} !== 3'b010 || glitch_cnt !== 8'd0) begin
            fails++;
            $display("FAIL async_rst pok/por/req=%b%b%b glitch=%0d want 010/0",
                     pok, por_rst, rel_req, glitch_cnt);
        end
        tick();
        rst     = 1'b0;
        vcc_pok = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_clean_powerup();
        test_debounce_glitch();
        test_short_drop();
        test_handshake_stall();
        test_loss_ack_same_edge();
        test_saturation_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
